// File: rtl/cu_prefetch_command_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_prefetch_command_issue_pkg
// Description : Shared buffer-line types and prefetch issue FSM state
//               encoding for the compute-unit prefetch command path.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_prefetch_command_issue_pkg;

    // One prefetch command as exchanged with the stream engine and arbiter
    typedef struct packed {
        logic        valid;
        logic [7:0]  command;
        logic [7:0]  size;
        logic [7:0]  tag;
        logic [31:0] address;
    } CommandBufferLine;

    // One read response; only .valid matters to the issue block
    typedef struct packed {
        logic       valid;
        logic [7:0] tag;
        logic [7:0] response;
    } ResponseBufferLine;

    // FIFO status reported back to the stream engine control
    typedef struct packed {
        logic valid;
        logic empty;
        logic full;
        logic alfull;
    } BufferStatus;

    // Issue FSM: IDLE while disabled, STALL while the outstanding window is full
    typedef enum logic [1:0] {
        PREFETCH_IDLE  = 2'd0,
        PREFETCH_RUN   = 2'd1,
        PREFETCH_STALL = 2'd2
    } prefetch_fsm_state;

    localparam int COMMAND_LINE_WIDTH = $bits(CommandBufferLine);

endpackage
`default_nettype wire

// File: rtl/cu_command_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cu_command_fifo
// Description : Power-of-two command FIFO with wrap-around pointers and an
//               occupancy counter. The head entry is visible combinationally.
//               Caller guarantees write_en is only raised when a slot is free
//               (or is being freed by a same-cycle read).
// Revision    : 1.0 - initial release
// ============================================================================
module cu_command_fifo
    import cu_prefetch_command_issue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = COMMAND_LINE_WIDTH
) (
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     write_en,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         read_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    read_ptr;
    logic [PW-1:0]    write_ptr;
    logic [PW:0]      occupancy;

    assign read_data = storage[read_ptr];
    assign count     = occupancy;

    // Storage array: no reset needed, occupancy guards every read
    always_ff @(posedge clock) begin
        if (write_en) begin
            storage[write_ptr] <= write_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks write minus read
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            read_ptr  <= '0;
            write_ptr <= '0;
            occupancy <= '0;
        end else begin
            if (write_en) begin
                write_ptr <= write_ptr + PW'(1);
            end
            if (read_en) begin
                read_ptr <= read_ptr + PW'(1);
            end
            case ({write_en, read_en})
                2'b10:   occupancy <= occupancy + (PW+1)'(1);
                2'b01:   occupancy <= occupancy - (PW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cu_prefetch_command_issue.sv
`default_nettype none
// ============================================================================
// Module      : cu_prefetch_command_issue
// Description : Buffers prefetch commands from the stream engine, requests
//               the command arbiter, issues one command per grant and keeps
//               the number of unanswered commands under MAX_OUTSTANDING.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_prefetch_command_issue
    import cu_prefetch_command_issue_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int ALFULL_MARGIN   = 4,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                               clock,
    input  logic                               rstn,
    input  logic                               enabled_in,
    input  CommandBufferLine                   command_in,
    output BufferStatus                        command_buffer_status,
    output logic                               command_request,
    input  logic                               command_grant,
    output CommandBufferLine                   command_out,
    input  ResponseBufferLine                  response_in,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_count,
    output logic                               overflow_error
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] DEPTH_COUNT       = CW'(DEPTH);
    localparam logic [CW-1:0] ALFULL_LEVEL      = CW'(DEPTH - ALFULL_MARGIN);
    localparam logic [OW-1:0] OUTSTANDING_LIMIT = OW'(MAX_OUTSTANDING);

    logic                          enabled;
    prefetch_fsm_state             state;
    prefetch_fsm_state             state_next;
    logic                          request_next;
    logic [CW-1:0]                 fifo_count;
    logic [CW-1:0]                 count_next;
    logic [COMMAND_LINE_WIDTH-1:0] fifo_head;
    logic                          fifo_full;
    logic                          write_attempt;
    logic                          write_en;
    logic                          overflow_hit;
    logic                          pop;
    logic                          retire;
    logic [OW-1:0]                 outstanding_next;
    CommandBufferLine              out_next;
    logic                          unused_response_bits;

    // Only the valid bit of a response is meaningful here
    assign unused_response_bits = ^{response_in.tag, response_in.response};

    cu_command_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COMMAND_LINE_WIDTH)
    ) u_command_fifo (
        .clock      (clock),
        .rstn       (rstn),
        .write_en   (write_en),
        .write_data (command_in),
        .read_en    (pop),
        .read_data  (fifo_head),
        .count      (fifo_count)
    );

    // Status is a pure function of occupancy
    always_comb begin
        fifo_full                    = (fifo_count == DEPTH_COUNT);
        command_buffer_status.empty  = (fifo_count == '0);
        command_buffer_status.full   = fifo_full;
        command_buffer_status.alfull = (fifo_count >= ALFULL_LEVEL);
        command_buffer_status.valid  = (fifo_count != '0);
    end

    // Write/pop/retire qualification and next occupancy/outstanding values;
    // a same-cycle pop frees the head slot so a write into a full FIFO lands
    always_comb begin
        pop           = command_grant & command_request & enabled;
        write_attempt = command_in.valid & enabled;
        write_en      = write_attempt & (~fifo_full | pop);
        overflow_hit  = write_attempt & fifo_full & ~pop;
        retire        = response_in.valid & (outstanding_count != '0);

        case ({write_en, pop})
            2'b10:   count_next = fifo_count + CW'(1);
            2'b01:   count_next = fifo_count - CW'(1);
            default: count_next = fifo_count;
        endcase

        case ({pop, retire})
            2'b10:   outstanding_next = outstanding_count + OW'(1);
            2'b01:   outstanding_next = outstanding_count - OW'(1);
            default: outstanding_next = outstanding_count;
        endcase

        out_next = '0;
        if (pop) begin
            out_next       = CommandBufferLine'(fifo_head);
            out_next.valid = 1'b1;
        end
    end

    // Issue FSM next state; request is only offered from RUN with work queued
    always_comb begin
        state_next   = state;
        request_next = 1'b0;
        case (state)
            PREFETCH_IDLE: begin
                if (enabled) begin
                    state_next = (outstanding_next == OUTSTANDING_LIMIT) ?
                                 PREFETCH_STALL : PREFETCH_RUN;
                end
            end
            PREFETCH_RUN: begin
                if (!enabled) begin
                    state_next = PREFETCH_IDLE;
                end else if (pop && (outstanding_next == OUTSTANDING_LIMIT)) begin
                    state_next = PREFETCH_STALL;
                end
            end
            PREFETCH_STALL: begin
                if (!enabled) begin
                    state_next = PREFETCH_IDLE;
                end else if (retire) begin
                    state_next = PREFETCH_RUN;
                end
            end
            default: state_next = PREFETCH_IDLE;
        endcase
        request_next = (state_next == PREFETCH_RUN) && (count_next != '0);
    end

    // FSM state register
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state <= PREFETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered enable, request, issued command, outstanding counter, overflow flag
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled           <= 1'b0;
            command_request   <= 1'b0;
            command_out       <= '0;
            outstanding_count <= '0;
            overflow_error    <= 1'b0;
        end else begin
            enabled           <= enabled_in;
            command_request   <= request_next;
            command_out       <= out_next;
            outstanding_count <= outstanding_next;
            if (overflow_hit) begin
                overflow_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cu_prefetch_command_issue.md
CU_PREFETCH_COMMAND_ISSUE -- requirements
Module: cu_prefetch_command_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning command FIFO entries (power of two).
REQ-002 SHALL have parameter ALFULL_MARGIN, default 4, meaning free entries remaining when alfull asserts.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 32, meaning issued-but-unanswered command limit.
REQ-004 SHALL have port clock  in  1  clock; reset rstn, asynchronous, active-low; clock clock.
REQ-005 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL have port enabled_in  in  1  block enable; registered one cycle internally.
REQ-007 SHALL have port command_in  in  CommandBufferLine  prefetch commands from the stream engine control; written when .valid.
REQ-008 SHALL have port command_buffer_status  out  BufferStatus  FIFO status (empty, full, alfull, valid) returned to the stream engine control.
REQ-009 SHALL have port command_request  out  1  request to the command arbiter.
REQ-010 SHALL have port command_grant  in  1  arbiter grant, single-cycle pulse.
REQ-011 SHALL have port command_out  out  CommandBufferLine  issued command to the arbiter.
REQ-012 SHALL have port response_in  in  ResponseBufferLine  read responses; .valid retires one outstanding command.
REQ-013 SHALL have port outstanding_count  out  $clog2(MAX_OUTSTANDING)+1  current outstanding commands.
REQ-014 SHALL have port overflow_error  out  1  sticky: write attempted while FIFO full.

Function
REQ-015 SHALL register enabled_in to an internal enabled; when enabled low, no FIFO writes, no requests, and command_out.valid is 0.
REQ-016 SHALL write command_in into the FIFO in the cycle it is valid, enabled is 1, and the FIFO is not full.
REQ-017 SHALL set overflow_error on a valid write while full, drop that command, and hold the flag until reset.
REQ-018 SHALL drive status combinationally from the occupancy counter: empty = (count==0), full = (count==DEPTH), alfull = (count >= DEPTH-ALFULL_MARGIN), valid = !empty.
REQ-019 SHALL implement a three-state FSM: IDLE (enabled low), RUN, STALL (outstanding_count == MAX_OUTSTANDING).
REQ-020 SHALL transition IDLE->RUN when enabled; RUN->STALL when an issue brings outstanding to MAX_OUTSTANDING; STALL->RUN on a retiring response; any state->IDLE when enabled falls (FIFO contents retained).
REQ-021 SHALL assert command_request only in RUN with FIFO non-empty, as a registered output.
REQ-022 SHALL, on command_grant while command_request is 1, pop the FIFO head and present it on command_out with .valid=1 the next cycle; command_out.valid SHALL be 0 in all other cycles.
REQ-023 SHALL deassert command_request in the cycle after a grant if the pop emptied the FIFO or reached MAX_OUTSTANDING; a grant with command_request low SHALL be ignored.
REQ-024 SHALL increment outstanding_count on each issue and decrement on each response_in.valid; simultaneous issue and response SHALL leave it unchanged.
REQ-025 SHALL ignore response_in.valid when outstanding_count is 0 (no underflow).
REQ-026 SHALL support simultaneous FIFO write and pop in one cycle with occupancy unchanged, including when full (pop frees the slot first).
REQ-027 SHALL use wrap-around read/write pointers of $clog2(DEPTH) bits.

Reset
REQ-028 SHALL, on rstn low, immediately clear FIFO pointers, occupancy, outstanding_count, overflow_error, command_request, command_out (all fields 0), and set FSM to IDLE; status reads empty=1, others 0.
REQ-029 SHALL discard all in-flight commands on reset mid-operation; responses arriving after reset release are ignored while outstanding_count is 0.

Structure
REQ-030 SHALL take CommandBufferLine, ResponseBufferLine, BufferStatus from CU_PKG/AFU_PKG; the FSM state enum SHALL be added to CU_PKG.
REQ-031 SHALL instantiate one sub-module, cu_command_fifo (parameterised DEPTH, width of CommandBufferLine), holding storage and pointers.

Verification
REQ-032 SHALL verify: 12 back-to-back writes, no grants -> alfull=1 at count 12, full=0, empty=0.
REQ-033 SHALL verify: 17 writes into DEPTH=16 -> 17th dropped, overflow_error=1 sticky, count=16.
REQ-034 SHALL verify: 3 commands queued, grant every cycle -> command_out.valid 3 consecutive cycles in FIFO order, outstanding_count=3, request low afterwards.
REQ-035 SHALL verify: MAX_OUTSTANDING=2, 4 queued -> 2 issued, STALL, request low; one response -> RUN, third issued.
REQ-036 SHALL verify: grant and response_in.valid in same cycle with outstanding=5 -> outstanding stays 5.
REQ-037 SHALL verify: rstn pulsed low with 8 queued, 4 outstanding -> all outputs zero, status empty=1, FSM IDLE.
